// File: rtl/ram_dump_reader.sv
// Streams a word-aligned range of the byte-addressed data RAM out as big-endian 32-bit words.
// Each word carries its byte address over a valid/ready handshake.
module ram_dump_reader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [31:0]       word_data,
  output logic [ADDR_W-1:0] word_addr
);

  typedef enum logic [1:0] {StIdle, StRead, StOut, StDone} state_e;

  localparam int unsigned SumW = ADDR_W + CNT_W + 2;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [2:0]        k_q, k_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              err_q, err_d;

  logic [SumW-1:0]   end_addr;
  logic              req_bad;
  logic              rd_active;
  logic [ADDR_W-1:0] rd_addr;

  // Wide enough that base + 4*count never wraps; ending exactly at the top is legal.
  assign end_addr  = SumW'(base_addr) + (SumW'(word_count) << 2);
  assign req_bad   = (base_addr[1:0] != 2'b00) || (end_addr > (SumW'(1) << ADDR_W));
  assign rd_active = (state_q == StRead) && (k_q < 3'd4);
  assign rd_addr   = cur_q + ADDR_W'(k_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start && !req_bad) begin
          state_d = (word_count == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (k_q == 3'd4) state_d = StOut;
      end
      StOut: begin
        if (word_ready) state_d = (rem_q == CNT_W'(1)) ? StDone : StRead;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    err        = err_q;
    mem_rd     = rd_active;
    mem_addr   = rd_active ? rd_addr : mem_addr_q;
    word_valid = (state_q == StOut);
    word_data  = data_q;
    word_addr  = cur_q;
  end

  always_comb begin
    cur_d      = cur_q;
    rem_d      = rem_q;
    k_d        = k_q;
    data_d     = data_q;
    mem_addr_d = mem_addr_q;
    err_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            cur_d = base_addr;
            rem_d = word_count;
            k_d   = 3'd0;
          end
        end
      end
      StRead: begin
        k_d = (k_q == 3'd4) ? 3'd0 : k_q + 3'd1;
        if (rd_active) mem_addr_d = rd_addr;
        // RAM data lags the strobe by one cycle, so lane k-1 lands while k is issued.
        case (k_q)
          3'd1:    data_d[31:24] = mem_rdata;
          3'd2:    data_d[23:16] = mem_rdata;
          3'd3:    data_d[15:8]  = mem_rdata;
          3'd4:    data_d[7:0]   = mem_rdata;
          default: ;
        endcase
      end
      StOut: begin
        if (word_ready) begin
          rem_d = rem_q - CNT_W'(1);
          cur_d = cur_q + ADDR_W'(4);
          k_d   = 3'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q      <= '0;
      rem_q      <= '0;
      k_q        <= '0;
      data_q     <= '0;
      mem_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      k_q        <= k_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench for ram_dump_reader with a one-cycle-latency byte RAM model.
module tb_ram_dump_reader;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy, done, err, mem_rd, word_valid;
  logic [ADDR_W-1:0] mem_addr, word_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic              word_ready = 1'b0;
  logic [31:0]       word_data;

  logic [7:0] ram [512];

  int checks = 0;
  int passes = 0;

  int                done_cnt = 0;
  int                valid_cnt = 0;
  logic [ADDR_W-1:0] rd_q [$];
  logic [31:0]       wd_q [$];
  logic [ADDR_W-1:0] wa_q [$];

  ram_dump_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_addr  (word_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_rd) rd_q.push_back(mem_addr);
    if (done) done_cnt++;
    if (word_valid) valid_cnt++;
    if (word_valid && word_ready) begin
      wd_q.push_back(word_data);
      wa_q.push_back(word_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_word(input int a);
    return {ram[a], ram[a+1], ram[a+2], ram[a+3]};
  endfunction

  // Leaves the bench in the cycle right after the start edge.
  task automatic pulse_start(input int b, input int c);
    base_addr  = ADDR_W'(b);
    word_count = CNT_W'(c);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n0, w0, d0, v0, cyc;
    logic              pv, pr;
    logic [31:0]       pd;
    logic [ADDR_W-1:0] pa;

    for (int i = 0; i < 512; i++) ram[i] = 8'((i * 37 + 11) ^ (i >> 3));
    ram[56] = 8'h0A; ram[57] = 8'hBC; ram[58] = 8'h12; ram[59] = 8'h34;

    // Reset values
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_valid", word_valid, 0);
    check("rst_data", word_data, 0);
    check("rst_addr", word_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_done_err", {done, err}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single word at 56
    word_ready = 1'b1;
    n0 = rd_q.size(); w0 = wd_q.size(); d0 = done_cnt;
    pulse_start(56, 1);
    check("t1_mem_rd_t1", mem_rd, 1);
    check("t1_mem_addr_t1", mem_addr, 56);
    check("t1_busy", busy, 1);
    repeat (4) @(negedge clk);
    check("t1_valid_early", word_valid, 0);
    @(negedge clk);
    check("t1_valid", word_valid, 1);
    check("t1_data", word_data, 32'h0ABC1234);
    check("t1_addr", word_addr, 56);
    @(negedge clk);
    check("t1_valid_drop", word_valid, 0);
    check("t1_done", done, 1);
    @(negedge clk);
    check("t1_done_drop", done, 0);
    check("t1_idle", busy, 0);
    check("t1_rd_count", rd_q.size() - n0, 4);
    for (int i = 0; i < 4; i++) check("t1_rd_addr", rd_q[n0 + i], 56 + i);
    check("t1_words", wd_q.size() - w0, 1);
    check("t1_done_count", done_cnt - d0, 1);

    // Ten words with a stalling consumer
    w0 = wd_q.size(); d0 = done_cnt;
    word_ready = 1'b0;
    pulse_start(224, 10);
    cyc = 0; pv = 1'b0; pr = 1'b0; pd = '0; pa = '0;
    while (done !== 1'b1 && cyc < 600) begin
      if (pv && !pr) begin
        check("t2_stall_valid", word_valid, 1);
        check("t2_stall_data", word_data, pd);
        check("t2_stall_addr", word_addr, pa);
      end
      word_ready = ((cyc / 3) % 2) == 1;
      pv = word_valid; pr = word_ready; pd = word_data; pa = word_addr;
      @(negedge clk);
      cyc++;
    end
    check("t2_timeout", 32'(cyc < 600), 1);
    check("t2_words", wd_q.size() - w0, 10);
    for (int i = 0; i < 10; i++) begin
      if (w0 + i < wd_q.size()) begin
        check("t2_word_addr", wa_q[w0 + i], 224 + 4 * i);
        check("t2_word_data", wd_q[w0 + i], model_word(224 + 4 * i));
      end
    end
    word_ready = 1'b1;
    @(negedge clk);
    check("t2_done_count", done_cnt - d0, 1);
    check("t2_idle", busy, 0);

    // Rejected requests
    n0 = rd_q.size();
    pulse_start(57, 1);
    check("t3a_err", err, 1);
    check("t3a_busy", busy, 0);
    @(negedge clk);
    check("t3a_err_drop", err, 0);
    check("t3a_busy2", busy, 0);
    pulse_start(508, 2);
    check("t3b_err", err, 1);
    check("t3b_busy", busy, 0);
    @(negedge clk);
    check("t3b_busy2", busy, 0);
    check("t3_no_rd", rd_q.size() - n0, 0);

    // Top-of-RAM word is legal
    w0 = wd_q.size();
    pulse_start(508, 1);
    check("t3c_err", err, 0);
    wait_done("t3c_timeout", 20);
    check("t3c_words", wd_q.size() - w0, 1);
    if (wd_q.size() > w0) begin
      check("t3c_addr", wa_q[w0], 508);
      check("t3c_data", wd_q[w0], model_word(508));
    end
    @(negedge clk);

    // Zero-length dump
    n0 = rd_q.size(); v0 = valid_cnt; d0 = done_cnt;
    pulse_start(0, 0);
    check("t4_done", done, 1);
    check("t4_mem_rd", mem_rd, 0);
    @(negedge clk);
    check("t4_done_drop", done, 0);
    check("t4_idle", busy, 0);
    check("t4_no_valid", valid_cnt - v0, 0);
    check("t4_no_rd", rd_q.size() - n0, 0);
    check("t4_done_count", done_cnt - d0, 1);

    // Start pulses while busy are ignored
    w0 = wd_q.size(); d0 = done_cnt;
    pulse_start(100, 3);
    base_addr = '0; word_count = CNT_W'(5);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      start = (cyc % 4 == 1) && busy;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("t5_timeout", 32'(cyc < 100), 1);
    repeat (3) @(negedge clk);
    check("t5_words", wd_q.size() - w0, 3);
    for (int i = 0; i < 3; i++) begin
      if (w0 + i < wd_q.size()) check("t5_word_addr", wa_q[w0 + i], 100 + 4 * i);
    end
    check("t5_done_count", done_cnt - d0, 1);
    check("t5_idle", busy, 0);

    // Reset during the second word's READ
    d0 = done_cnt;
    pulse_start(200, 4);
    repeat (7) @(negedge clk);
    check("t6_in_read", mem_rd, 1);
    reset = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_mem_rd", mem_rd, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_valid", word_valid, 0);
    check("t6_data", word_data, 0);
    check("t6_addr", word_addr, 0);
    check("t6_done_err", {done, err}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_idle_after", busy, 0);
    check("t6_no_done", done_cnt - d0, 0);
    w0 = wd_q.size();
    pulse_start(44, 1);
    wait_done("t6_timeout", 20);
    check("t6_words", wd_q.size() - w0, 1);
    if (wd_q.size() > w0) begin
      check("t6_new_addr", wa_q[w0], 44);
      check("t6_new_data", wd_q[w0], model_word(44));
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
